// File: rtl/inst_rom_arbiter_if.sv
// Bus between the two ROM requesters, the instruction ROM and the arbiter.
// The slave modport is the arbiter; the master modport is whatever drives requests and models the ROM.
interface inst_rom_arbiter_if #(
    parameter int ROM_AW = 17,
    parameter int WCW    = 3
);
    // Handshake: a requester raises req with its addr and holds them until gnt is seen high in the
    // same cycle; gnt is the accept. rvalid is a one-cycle pulse RD_LAT cycles after the accept,
    // carrying rdata. There is no back-pressure on the response side.
    logic              if_req_i;
    logic [31:0]       if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [31:0]       if_rdata_o;

    logic              ls_req_i;
    logic [31:0]       ls_addr_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [31:0]       ls_rdata_o;

    logic              rom_ce_o;
    logic [ROM_AW-1:0] rom_addr_o;
    logic [31:0]       rom_data_i;

    logic              dbg_last_owner;
    logic [WCW-1:0]    dbg_wait_cnt;

    modport slave (
        input  if_req_i, if_addr_i, ls_req_i, ls_addr_i, rom_data_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        output rom_ce_o, rom_addr_o, dbg_last_owner, dbg_wait_cnt
    );

    modport master (
        output if_req_i, if_addr_i, ls_req_i, ls_addr_i, rom_data_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        input  rom_ce_o, rom_addr_o, dbg_last_owner, dbg_wait_cnt
    );
endinterface

// File: rtl/inst_rom_arbiter.sv
// Shares the single-port instruction ROM between fetch and load/store, one read per cycle,
// and routes each response back to its owner through a tag pipeline matched to ROM latency.
module inst_rom_arbiter #(
    parameter int ROM_AW    = 17,
    parameter int RD_LAT    = 1,
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 7
) (
    input logic               clk,
    input logic               rst,
    inst_rom_arbiter_if.slave bus
);
    localparam int WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
            $error("inst_rom_arbiter: RD_LAT must be in 1..4");
        end
        if (ROM_AW < 1 || ROM_AW > 29) begin : g_bad_aw
            $error("inst_rom_arbiter: ROM_AW must be in 1..29");
        end
    endgenerate

    owner_e            last_owner;
    logic [WCW-1:0]    wait_cnt;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_ls;
    logic              if_gnt;
    logic              ls_gnt;
    logic              ce;
    logic [ROM_AW-1:0] rom_addr;
    logic              if_rv;
    logic              ls_rv;
    logic              unused_addr_bits;

    // Grant is decided in the request cycle; reset suppresses every grant.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (rst) begin
            if (bus.if_req_i && bus.ls_req_i) begin
                if (PRIO_MODE == 0) begin
                    if (last_owner == OWN_LS) if_gnt = 1'b1;
                    else                      ls_gnt = 1'b1;
                end else begin
                    if (wait_cnt == WAIT_MAX) ls_gnt = 1'b1;
                    else                      if_gnt = 1'b1;
                end
            end else begin
                if_gnt = bus.if_req_i;
                ls_gnt = bus.ls_req_i;
            end
        end
    end

    assign ce = if_gnt | ls_gnt;

    // Byte address to word address; low two bits and bits above the ROM are dropped.
    always_comb begin
        rom_addr = '0;
        if (if_gnt)      rom_addr = bus.if_addr_i[ROM_AW+1:2];
        else if (ls_gnt) rom_addr = bus.ls_addr_i[ROM_AW+1:2];
    end

    assign unused_addr_bits = ^{bus.if_addr_i[31:ROM_AW+2], bus.if_addr_i[1:0],
                                bus.ls_addr_i[31:ROM_AW+2], bus.ls_addr_i[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_owner <= OWN_LS;
            wait_cnt   <= '0;
            tag_v      <= '0;
            tag_ls     <= '0;
        end else begin
            if (ce) last_owner <= ls_gnt ? OWN_LS : OWN_IF;

            if (bus.ls_req_i && !ls_gnt) begin
                if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WCW'(1);
            end else begin
                wait_cnt <= '0;
            end

            // Stage RD_LAT-1 lines up with the ROM data of the read issued RD_LAT cycles ago.
            tag_v[0]  <= ce;
            tag_ls[0] <= ls_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_ls[i] <= tag_ls[i-1];
            end
        end
    end

    assign if_rv = rst & tag_v[RD_LAT-1] & ~tag_ls[RD_LAT-1];
    assign ls_rv = rst & tag_v[RD_LAT-1] &  tag_ls[RD_LAT-1];

    assign bus.if_gnt_o       = if_gnt;
    assign bus.ls_gnt_o       = ls_gnt;
    assign bus.rom_ce_o       = ce;
    assign bus.rom_addr_o     = rom_addr;
    assign bus.if_rvalid_o    = if_rv;
    assign bus.ls_rvalid_o    = ls_rv;
    assign bus.if_rdata_o     = if_rv ? bus.rom_data_i : 32'h0;
    assign bus.ls_rdata_o     = ls_rv ? bus.rom_data_i : 32'h0;
    assign bus.dbg_last_owner = last_owner;
    assign bus.dbg_wait_cnt   = wait_cnt;
endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Bench for inst_rom_arbiter: two configurations driven with the same stimulus, each checked
// every cycle against a behavioural model with an expected-response queue.
module tb_inst_rom_arbiter;
    localparam int A_AW = 17, A_LAT = 1, A_PRIO = 0, A_MAXW = 7, A_WCW = 3;
    localparam int B_AW = 4,  B_LAT = 3, B_PRIO = 1, B_MAXW = 3, B_WCW = 2;
    localparam int LOGN = 4096;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic        ls_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] ls_addr = '0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int d);   return (d == 0) ? A_LAT  : B_LAT;  endfunction
    function automatic int prio(input int d);  return (d == 0) ? A_PRIO : B_PRIO; endfunction
    function automatic int maxw(input int d);  return (d == 0) ? A_MAXW : B_MAXW; endfunction
    function automatic logic [31:0] amask(input int d);
        return (d == 0) ? ((32'h1 << A_AW) - 1) : ((32'h1 << B_AW) - 1);
    endfunction

    // ---------------- DUTs ----------------
    inst_rom_arbiter_if #(.ROM_AW(A_AW), .WCW(A_WCW)) bus_a ();
    inst_rom_arbiter_if #(.ROM_AW(B_AW), .WCW(B_WCW)) bus_b ();

    inst_rom_arbiter #(.ROM_AW(A_AW), .RD_LAT(A_LAT), .PRIO_MODE(A_PRIO), .MAX_WAIT(A_MAXW))
        u_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    inst_rom_arbiter #(.ROM_AW(B_AW), .RD_LAT(B_LAT), .PRIO_MODE(B_PRIO), .MAX_WAIT(B_MAXW))
        u_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    logic [31:0] rom_data [2];

    assign bus_a.if_req_i = if_req;   assign bus_b.if_req_i = if_req;
    assign bus_a.if_addr_i = if_addr; assign bus_b.if_addr_i = if_addr;
    assign bus_a.ls_req_i = ls_req;   assign bus_b.ls_req_i = ls_req;
    assign bus_a.ls_addr_i = ls_addr; assign bus_b.ls_addr_i = ls_addr;
    assign bus_a.rom_data_i = rom_data[0];
    assign bus_b.rom_data_i = rom_data[1];

    logic        o_if_g [2], o_ls_g [2], o_ce [2], o_if_rv [2], o_ls_rv [2], o_last [2];
    logic [31:0] o_addr [2], o_if_rd [2], o_ls_rd [2], o_wait [2];

    always_comb begin
        o_if_g[0] = bus_a.if_gnt_o;       o_if_g[1] = bus_b.if_gnt_o;
        o_ls_g[0] = bus_a.ls_gnt_o;       o_ls_g[1] = bus_b.ls_gnt_o;
        o_ce[0] = bus_a.rom_ce_o;         o_ce[1] = bus_b.rom_ce_o;
        o_if_rv[0] = bus_a.if_rvalid_o;   o_if_rv[1] = bus_b.if_rvalid_o;
        o_ls_rv[0] = bus_a.ls_rvalid_o;   o_ls_rv[1] = bus_b.ls_rvalid_o;
        o_last[0] = bus_a.dbg_last_owner; o_last[1] = bus_b.dbg_last_owner;
        o_addr[0] = 32'(bus_a.rom_addr_o); o_addr[1] = 32'(bus_b.rom_addr_o);
        o_if_rd[0] = bus_a.if_rdata_o;    o_if_rd[1] = bus_b.if_rdata_o;
        o_ls_rd[0] = bus_a.ls_rdata_o;    o_ls_rd[1] = bus_b.ls_rdata_o;
        o_wait[0] = 32'(bus_a.dbg_wait_cnt); o_wait[1] = 32'(bus_b.dbg_wait_cnt);
    end

    // ---------------- ROM environment: word w holds 0x34011100 + w ----------------
    logic [3:0]  hce [2] = '{4'b0, 4'b0};
    logic [31:0] haddr [2][4];
    logic [31:0] garb [2] = '{32'hDEAD0000, 32'hDEAD0001};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            hce[d] <= {hce[d][2:0], o_ce[d]};
            for (int i = 3; i > 0; i--) haddr[d][i] <= haddr[d][i-1];
            haddr[d][0] <= o_addr[d];
            garb[d] <= {16'hDEAD, 16'($urandom)};
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            rom_data[d] = hce[d][lat(d)-1] ? (32'h34011100 + haddr[d][lat(d)-1]) : garb[d];
        end
    end

    // ---------------- scoreboard / behavioural model ----------------
    // entry = {dut, due cycle[15:0], owner_is_ls, data[31:0]}
    logic [49:0] exp_q [$];
    int          m_last [2] = '{1, 1};
    int          m_wait [2] = '{0, 0};
    int          log_gnt [2][LOGN];
    int          log_rv [2][LOGN];
    int          log_wait [2][LOGN];
    logic [31:0] log_rd [2][LOGN];
    logic [31:0] log_addr [2][LOGN];
    bit          run = 1'b1;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h want %h", nm, d, cyc, act, exp);
        end
    endtask

    task automatic model_cycle(input int d);
        int          g;
        int          rv;
        bit          found;
        logic [31:0] ea;
        logic [31:0] rd;
        logic [49:0] e;
        g = 0; rv = 0; found = 1'b0; ea = '0; rd = '0; e = '0;

        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i][49] == d[0] && exp_q[i][48:33] == 16'(cyc)) begin
                e = exp_q[i];
                found = 1'b1;
                exp_q.delete(i);
                break;
            end
        end
        if (found && rst) begin
            rv = e[32] ? 2 : 1;
            rd = e[31:0];
        end

        if (rst) begin
            if (if_req && ls_req) begin
                if (prio(d) == 0) g = (m_last[d] == 1) ? 1 : 2;
                else              g = (m_wait[d] == maxw(d)) ? 2 : 1;
            end else if (if_req) g = 1;
            else if (ls_req)     g = 2;
        end
        if (g == 1) ea = (if_addr >> 2) & amask(d);
        if (g == 2) ea = (ls_addr >> 2) & amask(d);

        chk("if_gnt", d, 32'(o_if_g[d]), 32'(g == 1));
        chk("ls_gnt", d, 32'(o_ls_g[d]), 32'(g == 2));
        chk("rom_ce", d, 32'(o_ce[d]), 32'(g != 0));
        chk("rom_addr", d, o_addr[d], ea);
        chk("if_rvalid", d, 32'(o_if_rv[d]), 32'(rv == 1));
        chk("ls_rvalid", d, 32'(o_ls_rv[d]), 32'(rv == 2));
        chk("if_rdata", d, o_if_rd[d], (rv == 1) ? rd : 32'h0);
        chk("ls_rdata", d, o_ls_rd[d], (rv == 2) ? rd : 32'h0);
        if (rst) begin
            chk("last_owner", d, 32'(o_last[d]), 32'(m_last[d]));
            chk("wait_cnt", d, o_wait[d], 32'(m_wait[d]));
        end

        if (cyc < LOGN) begin
            log_gnt[d][cyc]  = g;
            log_rv[d][cyc]   = rv;
            log_rd[d][cyc]   = rd;
            log_addr[d][cyc] = ea;
            log_wait[d][cyc] = m_wait[d];
        end

        if (!rst) begin
            m_last[d] = 1;
            m_wait[d] = 0;
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i][49] == d[0]) exp_q.delete(i);
            end
        end else begin
            if (g != 0) m_last[d] = (g == 2) ? 1 : 0;
            if (ls_req && g != 2) m_wait[d] = (m_wait[d] == maxw(d)) ? m_wait[d] : m_wait[d] + 1;
            else                  m_wait[d] = 0;
            if (g != 0) exp_q.push_back({d[0], 16'(cyc + lat(d)), (g == 2), 32'h34011100 + ea});
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            model_cycle(0);
            model_cycle(1);
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        if_req = 1'b0;
        ls_req = 1'b0;
        repeat (n) step();
    endtask

    int p;

    initial begin
        // reset held with both requests high
        rst = 1'b0; if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h0; ls_addr = 32'h4;
        repeat (3) step();
        rst = 1'b1;
        p = cyc;
        step();
        chk("pin_first_gnt_if", 0, 32'(log_gnt[0][p]), 32'd1);
        chk("pin_first_gnt_if", 1, 32'(log_gnt[1][p]), 32'd1);
        idle(4);

        // fetch-only stream 0x0, 0x4, 0x8
        p = cyc;
        for (int k = 0; k < 3; k++) begin
            if_req = 1'b1; ls_req = 1'b0; if_addr = 32'(4 * k);
            step();
        end
        idle(5);
        for (int k = 0; k < 3; k++) begin
            chk("pin_fetch_gnt", 0, 32'(log_gnt[0][p+k]), 32'd1);
            chk("pin_fetch_rv", 0, 32'(log_rv[0][p+1+k]), 32'd1);
            chk("pin_fetch_rd", 0, log_rd[0][p+1+k], 32'h34011100 + 32'(k));
            chk("pin_fetch_rd_lat3", 1, log_rd[1][p+3+k], 32'h34011100 + 32'(k));
        end

        // both held after a fresh reset: round-robin vs priority with forced ls grant
        rst = 1'b0; step(); rst = 1'b1;
        p = cyc;
        if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h40; ls_addr = 32'h84;
        repeat (8) step();
        idle(5);
        for (int k = 0; k < 8; k++) begin
            chk("pin_rr_seq", 0, 32'(log_gnt[0][p+k]), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("pin_prio_seq", 1, 32'(log_gnt[1][p+k]), (k % 4 == 3) ? 32'd2 : 32'd1);
        end
        chk("pin_wait_max", 1, 32'(log_wait[1][p+3]), 32'd3);
        chk("pin_wait_clear", 1, 32'(log_wait[1][p+4]), 32'd0);

        // ls then if, latency 3, then the same with a reset in between
        p = cyc;
        ls_req = 1'b1; ls_addr = 32'h8; step();
        ls_req = 1'b0; if_req = 1'b1; if_addr = 32'hC; step();
        idle(5);
        chk("pin_lat3_ls_rv", 1, 32'(log_rv[1][p+3]), 32'd2);
        chk("pin_lat3_if_rv", 1, 32'(log_rv[1][p+4]), 32'd1);
        chk("pin_lat3_ls_rd", 1, log_rd[1][p+3], 32'h34011102);
        chk("pin_lat3_if_rd", 1, log_rd[1][p+4], 32'h34011103);
        p = cyc;
        ls_req = 1'b1; ls_addr = 32'h8; step();
        ls_req = 1'b0; if_req = 1'b1; if_addr = 32'hC; step();
        if_req = 1'b0; rst = 1'b0; step(); rst = 1'b1;
        idle(5);
        chk("pin_flush_13", 1, 32'(log_rv[1][p+3]), 32'd0);
        chk("pin_flush_14", 1, 32'(log_rv[1][p+4]), 32'd0);

        // address truncation
        p = cyc;
        ls_req = 1'b1; ls_addr = 32'h0000_0047; step();
        idle(5);
        chk("pin_trunc_aw4", 1, log_addr[1][p], 32'h1);
        chk("pin_trunc_aw17", 0, log_addr[0][p], 32'h11);

        // randomized traffic with occasional resets
        repeat (2000) begin
            rst     = ($urandom_range(0, 63) != 0);
            if_req  = ($urandom_range(0, 3) != 0);
            ls_req  = ($urandom_range(0, 3) != 0);
            if_addr = $urandom;
            ls_addr = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
            step();
        end
        rst = 1'b1;
        idle(6);

        chk("queue_drained", 0, 32'(exp_q.size()), 32'd0);
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
